// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: write-back select codes, RV32I
// load/store funct3 codes, the access FSM encoding and a small address helper.
package memory_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Write-back source select as carried down the pipeline
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access sequencer: IDLE issues requests, WAIT_RSP waits for load data
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } memState_e;

  // The data memory is word addressed; lane selection is done with byte enables
  function automatic logic [31:0] wordAddr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Combinational lane logic for the memory stage: alignment check, byte-enable
// and store-data replication for writes, lane select and extension for reads.
module load_store_align
  import memory_stage_pkg::*;
(
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLow,
  input  logic [31:0] storeData,
  input  logic [31:0] rawRdata,
  output logic        aligned,
  output logic [3:0]  byteEn,
  output logic [31:0] wdata,
  output logic [31:0] loadData
);

  logic [31:0] shiftedRdata;

  // Move the addressed byte/half down to bit 0 before extension
  assign shiftedRdata = rawRdata >> {addrLow, 3'b000};

  // Size decode: an unrecognised funct3 reports misaligned so no request is made
  always_comb begin
    aligned = 1'b0;
    byteEn  = 4'b0000;
    wdata   = 32'h0000_0000;
    if (isStore) begin
      case (funct3)
        F3_SB: begin
          aligned = 1'b1;
          byteEn  = 4'b0001 << addrLow;
          wdata   = {4{storeData[7:0]}};
        end
        F3_SH: begin
          aligned = ~addrLow[0];
          byteEn  = 4'b0011 << addrLow;
          wdata   = {2{storeData[15:0]}};
        end
        F3_SW: begin
          aligned = (addrLow == 2'b00);
          byteEn  = 4'b1111;
          wdata   = storeData;
        end
        default: begin
          aligned = 1'b0;
        end
      endcase
    end else begin
      byteEn = 4'b1111;
      case (funct3)
        F3_LB, F3_LBU: aligned = 1'b1;
        F3_LH, F3_LHU: aligned = ~addrLow[0];
        F3_LW:         aligned = (addrLow == 2'b00);
        default:       aligned = 1'b0;
      endcase
    end
  end

  // Read formatting; word loads are only used when aligned, so the shift is zero
  always_comb begin
    loadData = 32'h0000_0000;
    case (funct3)
      F3_LB:   loadData = {{24{shiftedRdata[7]}}, shiftedRdata[7:0]};
      F3_LBU:  loadData = {24'h000000, shiftedRdata[7:0]};
      F3_LH:   loadData = {{16{shiftedRdata[15]}}, shiftedRdata[15:0]};
      F3_LHU:  loadData = {16'h0000, shiftedRdata[15:0]};
      F3_LW:   loadData = shiftedRdata;
      default: loadData = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues load/store requests over a valid/ready data
// port, stalls the front of the pipe while an access is outstanding, and
// drives the MEM/WB register feeding write-back.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwriteM,
  input  logic            memrwM,
  input  logic [1:0]      wbselM,
  input  logic [2:0]      funct3M,
  input  logic [4:0]      rdM,
  input  logic [XLEN-1:0] ALUresM,
  input  logic [XLEN-1:0] data_writeM,
  input  logic [XLEN-1:0] pc4M,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_mem,
  output logic            misalign_trap,
  output logic            regwriteW,
  output logic [4:0]      rdW,
  output logic [1:0]      wbselW,
  output logic [XLEN-1:0] ALUresW,
  output logic [XLEN-1:0] read_dataW,
  output logic [XLEN-1:0] pc4W
);

  memState_e   state;
  memState_e   nextState;
  logic        isLoad;
  logic        isStore;
  logic        isAccess;
  logic        isAligned;
  logic        misalignNow;
  logic        rspCapture;
  logic        reqValid;
  logic        stallMem;
  logic [3:0]  alignBe;
  logic [31:0] alignWdata;
  logic [31:0] loadData;

  assign isLoad   = (wbselM == WB_MEM);
  assign isStore  = memrwM;
  assign isAccess = isLoad | isStore;

  load_store_align uAlign (
    .isStore   (isStore),
    .funct3    (funct3M),
    .addrLow   (ALUresM[1:0]),
    .storeData (data_writeM),
    .rawRdata  (dmem_rdata),
    .aligned   (isAligned),
    .byteEn    (alignBe),
    .wdata     (alignWdata),
    .loadData  (loadData)
  );

  assign misalignNow = (state == IDLE) & isAccess & ~isAligned;
  assign rspCapture  = (state == WAIT_RSP) & dmem_rsp_valid;

  // Access sequencer state register; reset abandons any outstanding load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Request/stall decode and next state; stores finish on accept, loads wait for data
  always_comb begin
    nextState = state;
    reqValid  = 1'b0;
    stallMem  = 1'b0;
    case (state)
      IDLE: begin
        if (isAccess && isAligned) begin
          reqValid = 1'b1;
          if (dmem_req_ready) begin
            if (isStore) begin
              stallMem = 1'b0;
            end else begin
              stallMem  = 1'b1;
              nextState = WAIT_RSP;
            end
          end else begin
            stallMem = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        stallMem = ~dmem_rsp_valid;
        if (dmem_rsp_valid) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign dmem_req_valid = reqValid;
  assign dmem_req_we    = reqValid & isStore;
  assign dmem_addr      = reqValid ? wordAddr(ALUresM) : '0;
  assign dmem_be        = reqValid ? alignBe : 4'b0000;
  assign dmem_wdata     = reqValid ? alignWdata : '0;
  assign stall_mem      = stallMem;

  // MEM/WB register: bubbles while stalled, suppresses writes on misaligned access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwriteW  <= 1'b0;
      rdW        <= 5'd0;
      wbselW     <= 2'b00;
      ALUresW    <= '0;
      read_dataW <= '0;
      pc4W       <= '0;
    end else if (stallMem) begin
      regwriteW <= 1'b0;
    end else begin
      regwriteW <= regwriteM & ~misalignNow;
      rdW       <= rdM;
      wbselW    <= wbselM;
      ALUresW   <= ALUresM;
      pc4W      <= pc4M;
      if (rspCapture) begin
        read_dataW <= loadData;
      end
    end
  end

  // One-cycle trap pulse for a misaligned or malformed access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_trap <= 1'b0;
    end else begin
      misalign_trap <= misalignNow;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised self-checking bench for memory_stage. A transaction-level model
// predicts request fields, stall cycles and MEM/WB contents for each operation;
// the bench also acts as the data memory with random ready and response delays.
module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        regwriteM;
  logic        memrwM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] ALUresM;
  logic [31:0] data_writeM;
  logic [31:0] pc4M;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        stall_mem;
  logic        misalign_trap;
  logic        regwriteW;
  logic [4:0]  rdW;
  logic [1:0]  wbselW;
  logic [31:0] ALUresW;
  logic [31:0] read_dataW;
  logic [31:0] pc4W;

  int checks   = 0;
  int failures = 0;

  logic        expRegwrite;
  logic [4:0]  expRd;
  logic [1:0]  expWb;
  logic [31:0] expAlu;
  logic [31:0] expRead;
  logic [31:0] expPc4;

  memory_stage dut (
    .clk            (clk),
    .rst            (rst),
    .regwriteM      (regwriteM),
    .memrwM         (memrwM),
    .wbselM         (wbselM),
    .funct3M        (funct3M),
    .rdM            (rdM),
    .ALUresM        (ALUresM),
    .data_writeM    (data_writeM),
    .pc4M           (pc4M),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .stall_mem      (stall_mem),
    .misalign_trap  (misalign_trap),
    .regwriteW      (regwriteW),
    .rdW            (rdW),
    .wbselW         (wbselW),
    .ALUresW        (ALUresW),
    .read_dataW     (read_dataW),
    .pc4W           (pc4W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against any unforeseen hang
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Access size in bytes for a legal funct3, 0 for an illegal one
  function automatic int accessSize(input logic st, input logic [2:0] f3);
    int size;
    size = 0;
    if (st) begin
      if (f3 == 3'd0) size = 1;
      else if (f3 == 3'd1) size = 2;
      else if (f3 == 3'd2) size = 4;
    end else begin
      if (f3 == 3'd0 || f3 == 3'd4) size = 1;
      else if (f3 == 3'd1 || f3 == 3'd5) size = 2;
      else if (f3 == 3'd2) size = 4;
    end
    return size;
  endfunction

  function automatic logic modelAligned(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = accessSize(st, f3);
    if (size == 0) return 1'b0;
    return (int'(a[1:0]) % size) == 0;
  endfunction

  function automatic logic [3:0] modelBe(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    int mask;
    if (!st) return 4'b1111;
    size = accessSize(st, f3);
    mask = (1 << size) - 1;
    return 4'(mask << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] raw);
    logic [31:0] v;
    v = raw >> (8 * int'(a[1:0]));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = raw;
    endcase
    return v;
  endfunction

  task automatic checkMemWb(input logic expTrap);
    checkOutput("regwriteW", 32'(regwriteW), 32'(expRegwrite));
    checkOutput("rdW", 32'(rdW), 32'(expRd));
    checkOutput("wbselW", 32'(wbselW), 32'(expWb));
    checkOutput("ALUresW", ALUresW, expAlu);
    checkOutput("pc4W", pc4W, expPc4);
    checkOutput("read_dataW", read_dataW, expRead);
    checkOutput("misalign_trap", 32'(misalign_trap), 32'(expTrap));
  endtask

  task automatic captureExpected(input logic rw, input logic [4:0] rd, input logic [1:0] wb,
                                 input logic [31:0] alu, input logic [31:0] pc4);
    expRegwrite = rw;
    expRd       = rd;
    expWb       = wb;
    expAlu      = alu;
    expPc4      = pc4;
  endtask

  // Drive one EX/MEM operation until it leaves the stage, playing the memory side
  task automatic applyStimulus(input logic rw, input logic st, input logic [1:0] wb, input logic [2:0] f3,
                               input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                               input logic [31:0] pc4, input int readyDelay, input int rspDelay,
                               input logic [31:0] rdata);
    logic isLoad;
    logic isAccess;
    logic ok;
    isLoad   = (wb == 2'b01);
    isAccess = isLoad | st;
    ok       = modelAligned(st, f3, alu);
    @(negedge clk);
    regwriteM   = rw;
    memrwM      = st;
    wbselM      = wb;
    funct3M     = f3;
    rdM         = rd;
    ALUresM     = alu;
    data_writeM = sd;
    pc4M        = pc4;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    if (!isAccess || !ok) begin
      dmem_req_ready = 1'($urandom_range(0, 1));
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      dmem_rdata     = $urandom;
      #1;
      checkOutput("reqValidIdle", 32'(dmem_req_valid), 32'd0);
      checkOutput("stallIdle", 32'(stall_mem), 32'd0);
      @(posedge clk);
      #1;
      captureExpected(rw & ~isAccess, rd, wb, alu, pc4);
      checkMemWb(isAccess);
    end else begin
      for (int k = 0; k <= readyDelay; k++) begin
        if (k > 0) @(negedge clk);
        dmem_req_ready = (k == readyDelay);
        dmem_rdata     = $urandom;
        #1;
        checkOutput("reqValid", 32'(dmem_req_valid), 32'd1);
        checkOutput("reqWe", 32'(dmem_req_we), 32'(st));
        checkOutput("reqAddr", dmem_addr, alu & 32'hFFFF_FFFC);
        checkOutput("reqBe", 32'(dmem_be), 32'(modelBe(st, f3, alu)));
        if (st) checkOutput("reqWdata", dmem_wdata, modelWdata(f3, sd));
        checkOutput("stallReq", 32'(stall_mem), 32'(isLoad || (k < readyDelay)));
        @(posedge clk);
        #1;
        if (st && (k == readyDelay)) captureExpected(rw, rd, wb, alu, pc4);
        else expRegwrite = 1'b0;
        checkMemWb(1'b0);
      end
      if (isLoad) begin
        for (int j = 1; j <= rspDelay; j++) begin
          @(negedge clk);
          dmem_req_ready = 1'($urandom_range(0, 1));
          dmem_rsp_valid = (j == rspDelay);
          dmem_rdata     = (j == rspDelay) ? rdata : $urandom;
          #1;
          checkOutput("reqValidWait", 32'(dmem_req_valid), 32'd0);
          checkOutput("stallWait", 32'(stall_mem), 32'(j != rspDelay));
          @(posedge clk);
          #1;
          if (j == rspDelay) begin
            captureExpected(rw, rd, wb, alu, pc4);
            expRead = modelLoad(f3, alu, rdata);
          end else begin
            expRegwrite = 1'b0;
          end
          checkMemWb(1'b0);
        end
      end
    end
  endtask

  task automatic clearInputs();
    regwriteM      = 1'b0;
    memrwM         = 1'b0;
    wbselM         = 2'b00;
    funct3M        = 3'b000;
    rdM            = 5'd0;
    ALUresM        = 32'd0;
    data_writeM    = 32'd0;
    pc4M           = 32'd0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'd0;
  endtask

  task automatic checkResetState();
    captureExpected(1'b0, 5'd0, 2'b00, 32'd0, 32'd0);
    expRead = 32'd0;
    checkOutput("rstReqValid", 32'(dmem_req_valid), 32'd0);
    checkOutput("rstStall", 32'(stall_mem), 32'd0);
    checkMemWb(1'b0);
  endtask

  // Reset while a load waits for data, then a late response must be ignored
  task automatic resetMidAccess();
    applyStimulus(1'b1, 1'b0, 2'b01, 3'd0, 5'd9, 32'h0000_0400, 32'd0, 32'h44, 0, 1, 32'h0000_0055);
    @(negedge clk);
    regwriteM = 1'b1;
    memrwM = 1'b0;
    wbselM = 2'b01;
    funct3M = 3'd2;
    rdM = 5'd12;
    ALUresM = 32'h0000_0800;
    pc4M = 32'h0000_0050;
    dmem_req_ready = 1'b1;
    #1;
    checkOutput("midReqValid", 32'(dmem_req_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    #1;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checkOutput("lateRspStall", 32'(stall_mem), 32'd0);
    @(posedge clk);
    #1;
    checkMemWb(1'b0);
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    logic        rw;
    logic        st;
    logic [1:0]  wb;
    logic [2:0]  f3;
    logic [31:0] alu;
    int          kind;
    logic [2:0]  loadCodes [5];
    logic [2:0]  badLoad [3];
    loadCodes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    badLoad   = '{3'd3, 3'd6, 3'd7};

    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    checkResetState();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(1'b1, 1'b0, 2'b00, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 32'h0000_0010, 0, 1, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd0, 5'd0, 32'h0000_0103, 32'h0000_00AB, 32'h0000_0014, 0, 1, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b01, 3'd0, 5'd7, 32'h0000_0102, 32'd0, 32'h0000_0018, 2, 3, 32'h0080_0000);
    applyStimulus(1'b1, 1'b0, 2'b01, 3'd5, 5'd8, 32'h0000_0202, 32'd0, 32'h0000_001C, 0, 1, 32'h8001_0000);
    applyStimulus(1'b1, 1'b0, 2'b01, 3'd2, 5'd9, 32'h0000_0201, 32'd0, 32'h0000_0020, 0, 1, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd2, 5'd0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0024, 0, 1, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b01, 3'd2, 5'd10, 32'h0000_0300, 32'd0, 32'h0000_0028, 0, 1, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 2'b10, 3'd0, 5'd1, 32'h0000_0040, 32'd0, 32'h0000_002C, 0, 1, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 3'd1, 5'd0, 32'h0000_0306, 32'h0000_BEEF, 32'h0000_0030, 1, 1, 32'd0);

    $display("[TB] reset during outstanding load");
    resetMidAccess();

    $display("[TB] random operations");
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rw   = 1'($urandom_range(0, 1));
      alu  = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      st = 1'b0;
      wb = 2'b00;
      f3 = 3'($urandom_range(0, 7));
      if (kind <= 2) begin
        wb = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      end else if (kind <= 5) begin
        wb = 2'b01;
        f3 = loadCodes[$urandom_range(0, 4)];
      end else if (kind <= 8) begin
        st = 1'b1;
        rw = 1'b0;
        f3 = 3'($urandom_range(0, 2));
      end else if ($urandom_range(0, 1) == 1) begin
        wb = 2'b01;
        f3 = badLoad[$urandom_range(0, 2)];
      end else begin
        st = 1'b1;
        f3 = 3'($urandom_range(3, 7));
      end
      applyStimulus(rw, st, wb, f3, 5'($urandom), alu, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
